// File: rtl/bsh_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and field widths.
package bsh_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_ROL = 3'b000;
    localparam mode_t MODE_ROR = 3'b001;
    localparam mode_t MODE_SLL = 3'b010;
    localparam mode_t MODE_SRL = 3'b011;
    localparam mode_t MODE_SRA = 3'b100;

endpackage

// File: rtl/bsh_stage.sv
// One combinational barrel-shifter stage moving data by SH positions when enabled.
// BSH_SRA_EN selects sign fill for MODE_SRA; otherwise MODE_SRA behaves as MODE_SRL.
module bsh_stage
    import bsh_pkg::*;
#(
    parameter int N  = 8,
    parameter int SH = 1
) (
    input  logic [N-1:0] a,
    input  logic         en,
    input  mode_t        mode,
    input  logic         sign,
    output logic [N-1:0] y
);

    // Rotation wraps modulo N, so a stage of 2^i >= N still rotates correctly.
    localparam int R = SH % N;

    logic [N-1:0] rol;
    logic [N-1:0] ror;

    assign rol = (a << R) | (a >> (N - R));
    assign ror = (a >> R) | (a << (N - R));

`ifdef BSH_SRA_EN
    logic [N-1:0] sra_fill;
    assign sra_fill = ~({N{1'b1}} >> SH) & {N{sign}};
`else
    logic unused_sign;
    assign unused_sign = sign;
`endif

    always_comb begin
        // NOTE: default assigned first so no path through this block can infer a latch.
        y = a;
        if (en) begin
            case (mode)
                MODE_ROL: y = rol;
                MODE_ROR: y = ror;
                MODE_SLL: y = a << SH;
`ifdef BSH_SRA_EN
                MODE_SRL: y = a >> SH;
                MODE_SRA: y = (a >> SH) | sra_fill;
`else
                MODE_SRL, MODE_SRA: y = a >> SH;
`endif
                default:  y = a;
            endcase
        end
    end

endmodule

// File: rtl/bsh_pipe.sv
// Pipelined barrel shifter with valid/ready stream interface; one amount bit per stage, MSB first.
// BSH_SRA_EN enables the arithmetic right shift mode (sign captured per slot).
module bsh_pipe
    import bsh_pkg::*;
#(
    parameter int  N           = 8,
    parameter int  STG_PER_REG = 1,
    localparam int W           = $clog2(N)
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    output logic              oReady,
    input  logic [N-1:0]      iA,
    input  logic [W-1:0]      iAmt,
    input  logic [MODE_W-1:0] iMode,
    output logic              oValid,
    input  logic              iReady,
    output logic [N-1:0]      oY,
    output logic              oBusy
);

    localparam int L = (W + STG_PER_REG - 1) / STG_PER_REG;

    logic [L-1:0] valid_q;
    logic [L-1:0] load;
    logic [L-1:0] in_valid;
    logic [N-1:0] data_q   [L];
    logic [W-1:0] amt_q    [L];
    mode_t        mode_q   [L];
    logic [N-1:0] slot_d   [L];
    logic [W-1:0] slot_amt [L];
    mode_t        slot_mode[L];
`ifdef BSH_SRA_EN
    logic         sign_q   [L];
    logic         slot_sign[L];
`endif

    // Stage j consumes amount bit W-1-j; stages of slot K read slot K-1 (or the inputs for K=0).
    for (genvar j = 0; j < W; j++) begin : g_stage
        localparam int K = j / STG_PER_REG;
        logic [N-1:0] a_in;
        logic [N-1:0] y_out;
        logic         en;
        mode_t        mode_in;
        logic         sign_in;

        if (K == 0) begin : g_src_in
            assign en      = iAmt[W-1-j];
            assign mode_in = iMode;
`ifdef BSH_SRA_EN
            assign sign_in = iA[N-1];
`else
            assign sign_in = 1'b0;
`endif
        end else begin : g_src_slot
            assign en      = amt_q[K-1][W-1-j];
            assign mode_in = mode_q[K-1];
`ifdef BSH_SRA_EN
            assign sign_in = sign_q[K-1];
`else
            assign sign_in = 1'b0;
`endif
        end

        if (j % STG_PER_REG != 0) begin : g_chain
            assign a_in = g_stage[j-1].y_out;
        end else if (K == 0) begin : g_head_in
            assign a_in = iA;
        end else begin : g_head_slot
            assign a_in = data_q[K-1];
        end

        bsh_stage #(
            .N  (N),
            .SH (1 << (W - 1 - j))
        ) u_stage (
            .a    (a_in),
            .en   (en),
            .mode (mode_in),
            .sign (sign_in),
            .y    (y_out)
        );
    end

    for (genvar k = 0; k < L; k++) begin : g_slot
        localparam int LAST = (((k + 1) * STG_PER_REG < W) ? (k + 1) * STG_PER_REG : W) - 1;

        assign slot_d[k] = g_stage[LAST].y_out;
        if (k == 0) begin : g_first
            assign in_valid[k]  = iValid;
            assign slot_amt[k]  = iAmt;
            assign slot_mode[k] = iMode;
`ifdef BSH_SRA_EN
            assign slot_sign[k] = iA[N-1];
`endif
        end else begin : g_next
            assign in_valid[k]  = valid_q[k-1];
            assign slot_amt[k]  = amt_q[k-1];
            assign slot_mode[k] = mode_q[k-1];
`ifdef BSH_SRA_EN
            assign slot_sign[k] = sign_q[k-1];
`endif
        end
    end

    // A slot loads when any slot from it to the output is empty or the output drains.
    always_comb begin
        load = '0;
        for (int k = 0; k < L; k++) begin
            load[k] = iReady;
            for (int m = k; m < L; m++) begin
                if (!valid_q[m]) load[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            valid_q <= '0;
            // NOTE: slot payloads are reset too, so oY reads 0 after reset rather than stale data.
            for (int k = 0; k < L; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= MODE_ROL;
`ifdef BSH_SRA_EN
                sign_q[k] <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (load[k]) begin
                    valid_q[k] <= in_valid[k];
                    if (in_valid[k]) begin
                        data_q[k] <= slot_d[k];
                        amt_q[k]  <= slot_amt[k];
                        mode_q[k] <= slot_mode[k];
`ifdef BSH_SRA_EN
                        sign_q[k] <= slot_sign[k];
`endif
                    end
                end
            end
        end
    end

    assign oReady = load[0];
    assign oValid = valid_q[L-1];
    assign oY     = data_q[L-1];
    assign oBusy  = |valid_q;

endmodule

// File: doc/bsh_pipe.md
# bsh_pipe

Pipelined, parametrised barrel shifter with five shift/rotate modes and a valid/ready stream interface. Amount decoding is staged one bit per stage, most significant first, and pipeline registers are inserted every STG_PER_REG stages. It sustains one operation per clock and absorbs backpressure without losing data. It sits in the datapath wherever shifts must be timing-closed at high clock rates.

## Interface
- N, 8: data width, N ≥ 2, any value (not restricted to a power of two)
- W, $clog2(N): amount width; derived, do not override
- STG_PER_REG, 1: shift stages per register slot, 1..W; L = ceil(W/STG_PER_REG) register slots
- iClk  in  1  clock; all state on rising edge
- iRst_n  in  1  asynchronous active-low reset
- iValid  in  1  input operation valid
- oReady  out  1  block can accept input this cycle
- iA  in  N  operand
- iAmt  in  W  shift/rotate amount
- iMode  in  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101–111 reserved
- oValid  out  1  result valid
- iReady  in  1  downstream accepts result
- oY  out  N  result
- oBusy  out  1  any slot holds a valid operation

## Operation
- Transfer in: iValid && oReady. Transfer out: oValid && iReady.
- Each slot holds valid, data, remaining amount bits, mode, and sign (the captured iA[N-1]).
- Stage for amount bit i (i = W-1 down to 0) moves the data by 2^i when the bit is set:
  - ROL/ROR: rotate. The result is a rotate by iAmt mod N.
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: sign fill.
  - If 2^i ≥ N, a shift stage produces all fill bits.
- Shift by iAmt ≥ N: SLL/SRL give 0; SRA gives all sign bits.
- Amount 0: oY = iA for every mode.
- Reserved modes: oY = iA (pass-through).
- Slot advance rule: slot k loads when it is empty or slot k+1 (or the output, for the last slot) accepts in the same cycle. Bubbles collapse.
- oReady = load condition of slot 0, combinational from iReady through the chain.
- oValid = valid of the last slot. oY = data of the last slot; it is held stable while oValid && !iReady.
- Simultaneous in and out transfers in the same cycle are allowed and required at full occupancy.

## Timing
- Reset (async assert, sync-released by the system): all slot valids = 0, oValid = 0, oBusy = 0, oY = 0, internal data = 0. In-flight operations are discarded.
- Latency: an accepted input appears on oValid exactly L cycles later when not stalled.
- Throughput: 1 operation/cycle with iReady held high.
- Stall: iReady low for c cycles delays the in-flight outputs by c. Nothing is dropped or duplicated. Ordering is strictly FIFO.
- Full pipeline with iReady low: oReady = 0 in the same cycle.
- Combinational paths: iReady → oReady only. No path from iA/iAmt/iMode to any output.

## Configuration
- BSH_SRA_EN defined: mode 100 performs an arithmetic right shift as above.
- BSH_SRA_EN undefined: mode 100 behaves exactly as SRL (011). The sign bit is not stored in the slots, and the sign-fill logic is absent.

## Structure
- Package bsh_pkg holds:
  - mode encodings as localparams: MODE_ROL, MODE_ROR, MODE_SLL, MODE_SRL, MODE_SRA
  - the mode field width (3)
- Sub-module bsh_stage: combinational single stage.
  - Parameters N and SH (= 2^i).
  - Inputs: data, enable bit, mode, sign. Output: data.
  - Instantiated W times via generate.
  - Register slots are placed after every STG_PER_REG-th stage and after the final stage.

## Test plan
- N=8, STG_PER_REG=1 (L=3), iA=0x96, iAmt=3, each mode with iReady=1 → oY = ROL 0xB4, ROR 0xD2, SLL 0xB0, SRL 0x12, SRA 0xF2. oValid exactly 3 cycles after acceptance.
- iA=0x96, iAmt=2, SRA with and without BSH_SRA_EN → 0xE5 and 0x25 respectively. Reserved mode 111 → 0x96.
- N=6 (W=3), iA=6'b100101:
  - ROL by 5 → 6'b110010
  - SLL by 6 → 0
  - SRA by 7 → 6'b111111
- Streaming 16 back-to-back ops, iReady toggled pseudo-randomly → all 16 results in order, none lost or duplicated. oReady drops only when the pipeline is full and iReady=0.
- Fill 3 ops with iReady=0 → oReady=0, oY held stable. Release iReady → one result per cycle.
- Assert iRst_n low mid-stream with 2 ops in flight → oValid, oBusy, oY go to 0 immediately. No stale result appears after release.
